// File: rtl/cert_response_parser_pkg.sv
// Shared definitions for the CERTIFICATE response parser: message types,
// local error codes and one-hot FSM state encodings.
package cert_response_parser_pkg;

  localparam logic [7:0] MSG_TYPE_CERTIFICATE = 8'h02;
  localparam logic [7:0] MSG_TYPE_ERROR       = 8'h7F;

  localparam logic [7:0] ERR_PROTO_VER = 8'h01;
  localparam logic [7:0] ERR_MSG_TYPE  = 8'h02;
  localparam logic [7:0] ERR_SLOT      = 8'h03;
  localparam logic [7:0] ERR_TRUNCATED = 8'h04;
  localparam logic [7:0] ERR_OVERFLOW  = 8'h05;
  localparam logic [7:0] ERR_CHAIN_LEN = 8'h06;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    HDR     = 5'b00010,
    PAYLOAD = 5'b00100,
    DRAIN   = 5'b01000,
    DONE    = 5'b10000
  } parser_state_t;

endpackage

// File: rtl/cert_response_parser.sv
// Parses one CERTIFICATE response per request: validates the 4-byte header,
// forwards payload bytes to cert storage and reports a per-response verdict.
module cert_response_parser
  import cert_response_parser_pkg::*;
#(
  parameter int         CHUNK_LEN = 64,
  parameter logic [7:0] PROTO_VER = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  exp_slot,
  input  logic [15:0] exp_offset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_last,
  output logic [7:0]  cert_byte,
  output logic        cert_valid,
  output logic        resp_done,
  output logic        resp_valid,
  output logic        resp_error,
  output logic        err_remote,
  output logic [7:0]  err_code,
  output logic [15:0] chain_len,
  output logic [7:0]  expected_certificates,
  output logic        busy
);

  localparam int          CHUNK_SHIFT = $clog2(CHUNK_LEN);
  localparam logic [8:0]  CHUNK_MAX   = 9'(CHUNK_LEN);
  localparam logic [16:0] CHUNK_ROUND = 17'(CHUNK_LEN - 1);

  // Number of chunks needed to carry len bytes, clamped to the 8-bit output.
  function automatic logic [7:0] ceil_chunks(input logic [15:0] len);
    logic [16:0] quot;
    quot = ({1'b0, len} + CHUNK_ROUND) >> CHUNK_SHIFT;
    return (quot > 17'd255) ? 8'hFF : quot[7:0];
  endfunction

  parser_state_t state;
  logic [1:0]    hdr_idx;
  logic          is_error_msg;
  logic          first_chunk;
  logic          err_flag;
  logic [8:0]    pay_cnt;
  logic [15:0]   chain_tmp;

  logic          accept;
  logic [1:0]    hdr_pos;
  logic [8:0]    pay_next;
  logic [15:0]   chain_full;
  logic          fail;
  logic [7:0]    fail_code;
  logic          fail_remote;
  logic          go_done;
  logic          go_drain;
  logic          go_payload;
  logic          forward;
  logic          final_err;

  assign busy = (state != IDLE);

  // Per-byte decision: which check (if any) this byte fails and where the FSM goes.
  always_comb begin
    accept      = rx_valid && enable;
    hdr_pos     = (state == IDLE) ? 2'd0 : hdr_idx;
    pay_next    = pay_cnt + 9'd1;
    chain_full  = (pay_cnt == 9'd1) ? {rx_byte, chain_tmp[7:0]} : chain_tmp;
    fail        = 1'b0;
    fail_code   = 8'h00;
    fail_remote = 1'b0;
    go_done     = 1'b0;
    go_drain    = 1'b0;
    go_payload  = 1'b0;
    forward     = 1'b0;
    if (accept) begin
      case (state)
        IDLE, HDR: begin
          case (hdr_pos)
            2'd0: begin
              if (rx_byte != PROTO_VER) begin
                fail      = 1'b1;
                fail_code = ERR_PROTO_VER;
              end
            end
            2'd1: begin
              if (rx_byte != MSG_TYPE_CERTIFICATE && rx_byte != MSG_TYPE_ERROR) begin
                fail      = 1'b1;
                fail_code = ERR_MSG_TYPE;
              end
            end
            2'd2: begin
              if (is_error_msg) begin
                fail        = 1'b1;
                fail_code   = rx_byte;
                fail_remote = 1'b1;
              end else if (rx_byte[1:0] != exp_slot) begin
                fail      = 1'b1;
                fail_code = ERR_SLOT;
              end
            end
            default: ;
          endcase
          // A peer ERROR still walks through b3 before draining its body.
          if (fail) begin
            go_done  = rx_last;
            go_drain = !rx_last && !fail_remote;
          end else if (hdr_pos == 2'd3 && is_error_msg) begin
            go_done  = rx_last;
            go_drain = !rx_last;
          end else if (rx_last) begin
            fail      = 1'b1;
            fail_code = ERR_TRUNCATED;
            go_done   = 1'b1;
          end else if (hdr_pos == 2'd3) begin
            go_payload = 1'b1;
          end
        end
        PAYLOAD: begin
          if (pay_next > CHUNK_MAX) begin
            fail      = 1'b1;
            fail_code = ERR_OVERFLOW;
            go_done   = rx_last;
            go_drain  = !rx_last;
          end else begin
            forward = 1'b1;
            if (rx_last) begin
              go_done = 1'b1;
              if (first_chunk && (pay_next < 9'd2 || chain_full == 16'd0)) begin
                fail      = 1'b1;
                fail_code = ERR_CHAIN_LEN;
              end
            end
          end
        end
        DRAIN: go_done = rx_last;
        default: ;
      endcase
    end
    final_err = err_flag || fail;
  end

  // FSM and all registered outputs; an enable drop abandons the message silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      hdr_idx               <= 2'd0;
      is_error_msg          <= 1'b0;
      first_chunk           <= 1'b0;
      err_flag              <= 1'b0;
      pay_cnt               <= 9'd0;
      chain_tmp             <= 16'd0;
      cert_byte             <= 8'h00;
      cert_valid            <= 1'b0;
      resp_done             <= 1'b0;
      resp_valid            <= 1'b0;
      resp_error            <= 1'b0;
      err_remote            <= 1'b0;
      err_code              <= 8'h00;
      chain_len             <= 16'd0;
      expected_certificates <= 8'h00;
    end else begin
      cert_valid <= 1'b0;
      resp_done  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      if (state != IDLE && !enable) begin
        state     <= IDLE;
        hdr_idx   <= 2'd0;
        pay_cnt   <= 9'd0;
        err_flag  <= 1'b0;
        chain_tmp <= 16'd0;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (accept) begin
        if (state == IDLE) begin
          state        <= HDR;
          err_flag     <= 1'b0;
          err_code     <= 8'h00;
          err_remote   <= 1'b0;
          is_error_msg <= 1'b0;
          first_chunk  <= (exp_offset == 16'd0);
          pay_cnt      <= 9'd0;
          chain_tmp    <= 16'd0;
        end
        if (state == IDLE || state == HDR) begin
          hdr_idx <= hdr_pos + 2'd1;
        end
        if (state == HDR && hdr_idx == 2'd1) begin
          is_error_msg <= (rx_byte == MSG_TYPE_ERROR);
        end
        if (forward) begin
          cert_byte  <= rx_byte;
          cert_valid <= 1'b1;
          pay_cnt    <= pay_next;
          if (pay_cnt == 9'd0) chain_tmp[7:0]  <= rx_byte;
          if (pay_cnt == 9'd1) chain_tmp[15:8] <= rx_byte;
        end
        if (fail) begin
          err_flag   <= 1'b1;
          err_code   <= fail_code;
          err_remote <= fail_remote;
        end
        if (go_done) begin
          state      <= DONE;
          resp_done  <= 1'b1;
          resp_valid <= !final_err;
          resp_error <= final_err;
          if (!final_err && first_chunk) begin
            chain_len             <= chain_full;
            expected_certificates <= ceil_chunks(chain_full);
          end
        end else if (go_drain) begin
          state <= DRAIN;
        end else if (go_payload) begin
          state <= PAYLOAD;
        end
      end
    end
  end

endmodule
